rsa_keygen: RTL and testbench

//   Private-exponent generator: the key-side counterpart of the RSA modexp engine. Takes primes p, q
//   and public exponent e, computes n=p*q, phi=(p-1)*(q-1) and d=e^-1 mod phi by iterative extended

---
 rtl/rsa_pkg.sv | 17 +
 rtl/rsa_ext_euclid_step.sv | 26 ++
 rtl/rsa_keygen.sv | 168 ++++++++++++++++
 tb/tb_rsa_keygen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key generator: FSM states and default widths.
package rsa_pkg;

    localparam int PW_DEF       = 16;
    localparam int EW_DEF       = 32;
    localparam int MAX_ITER_DEF = 48;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CHECK,
        EUCLID,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/rsa_ext_euclid_step.sv
// One combinational iteration of the extended Euclid recurrence on (r0,r1,t0,t1).
module rsa_ext_euclid_step #(
    parameter int EW = 32
) (
    input  logic        [EW-1:0] r0_i,
    input  logic        [EW-1:0] r1_i,
    input  logic signed [EW+1:0] t0_i,
    input  logic signed [EW+1:0] t1_i,
    output logic        [EW-1:0] r0_o,
    output logic        [EW-1:0] r1_o,
    output logic signed [EW+1:0] t0_o,
    output logic signed [EW+1:0] t1_o
);

    logic [EW-1:0] qt;

    // Products are truncated to the operand width; |t| <= phi keeps them exact.
    always_comb begin
        qt   = (r1_i != '0) ? (r0_i / r1_i) : '0;
        r0_o = r1_i;
        r1_o = r0_i - qt * r1_i;
        t0_o = t1_i;
        t1_o = t0_i - $signed({2'b00, qt}) * t1_i;
    end

endmodule

// File: rtl/rsa_keygen.sv
// Computes n=p*q, phi=(p-1)*(q-1) and d=e^-1 mod phi, one Euclid step per clock.
module rsa_keygen
    import rsa_pkg::*;
#(
    parameter int PW       = PW_DEF,
    parameter int EW       = EW_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] p,
    input  logic [PW-1:0] q,
    input  logic [EW-1:0] e,
    output logic          busy,
    output logic          done,
    output logic [EW-1:0] n_o,
    output logic [EW-1:0] d_o,
    output logic          invalid
);

    localparam int IW = $clog2(MAX_ITER + 1);

    state_e                 state_q, state_d;
    logic        [PW-1:0]   p_q, p_d, q_q, q_d;
    logic        [EW-1:0]   e_q, e_d, n_q, n_d, phi_q, phi_d;
    logic        [EW-1:0]   r0_q, r0_d, r1_q, r1_d;
    logic signed [EW+1:0]   t0_q, t0_d, t1_q, t1_d;
    logic        [IW-1:0]   iter_q, iter_d;
    logic        [EW-1:0]   n_out_q, n_out_d, d_out_q, d_out_d;
    logic                   inv_out_q, inv_out_d;

    logic        [EW-1:0]   r0_s, r1_s;
    logic signed [EW+1:0]   t0_s, t1_s;

    rsa_ext_euclid_step #(.EW(EW)) u_step (
        .r0_i (r0_q),
        .r1_i (r1_q),
        .t0_i (t0_q),
        .t1_i (t1_q),
        .r0_o (r0_s),
        .r1_o (r1_s),
        .t0_o (t0_s),
        .t1_o (t1_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            p_q       <= '0;
            q_q       <= '0;
            e_q       <= '0;
            n_q       <= '0;
            phi_q     <= '0;
            r0_q      <= '0;
            r1_q      <= '0;
            t0_q      <= '0;
            t1_q      <= '0;
            iter_q    <= '0;
            n_out_q   <= '0;
            d_out_q   <= '0;
            inv_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            q_q       <= q_d;
            e_q       <= e_d;
            n_q       <= n_d;
            phi_q     <= phi_d;
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            t0_q      <= t0_d;
            t1_q      <= t1_d;
            iter_q    <= iter_d;
            n_out_q   <= n_out_d;
            d_out_q   <= d_out_d;
            inv_out_q <= inv_out_d;
        end
    end

    // Result registers load on the edge into DONE so they are valid with the done pulse.
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        q_d       = q_q;
        e_d       = e_q;
        n_d       = n_q;
        phi_d     = phi_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        t0_d      = t0_q;
        t1_d      = t1_q;
        iter_d    = iter_q;
        n_out_d   = n_out_q;
        d_out_d   = d_out_q;
        inv_out_d = inv_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d     = p;
                    q_d     = q;
                    e_d     = e;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                n_d     = EW'(p_q) * EW'(q_q);
                phi_d   = EW'(p_q - PW'(1)) * EW'(q_q - PW'(1));
                state_d = CHECK;
            end
            CHECK: begin
                if (p_q < PW'(2) || q_q < PW'(2) || e_q < EW'(2) || e_q >= phi_q) begin
                    n_out_d   = n_q;
                    d_out_d   = '0;
                    inv_out_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    r0_d    = phi_q;
                    r1_d    = e_q;
                    t0_d    = '0;
                    t1_d    = {{(EW+1){1'b0}}, 1'b1};
                    iter_d  = '0;
                    state_d = EUCLID;
                end
            end
            EUCLID: begin
                if (r1_q == '0) begin
                    state_d = FIX;
                end else if (iter_q == IW'(MAX_ITER)) begin
                    n_out_d   = n_q;
                    d_out_d   = '0;
                    inv_out_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    r0_d   = r0_s;
                    r1_d   = r1_s;
                    t0_d   = t0_s;
                    t1_d   = t1_s;
                    iter_d = iter_q + IW'(1);
                end
            end
            FIX: begin
                n_out_d = n_q;
                if (r0_q != EW'(1)) begin
                    d_out_d   = '0;
                    inv_out_d = 1'b1;
                end else begin
                    d_out_d   = t0_q[EW+1] ? (t0_q[EW-1:0] + phi_q) : t0_q[EW-1:0];
                    inv_out_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign n_o     = n_out_q;
    assign d_o     = d_out_q;
    assign invalid = inv_out_q;

endmodule

// File: tb/tb_rsa_keygen.sv
// Bench for rsa_keygen: directed table, hand-written corner sequences and random prime pairs.
module tb_rsa_keygen;

    localparam int PW       = 16;
    localparam int EW       = 32;
    localparam int MAX_ITER = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] p;
    logic [PW-1:0] q;
    logic [EW-1:0] e;
    logic          busy;
    logic          done;
    logic [EW-1:0] n_o;
    logic [EW-1:0] d_o;
    logic          invalid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rsa_keygen #(.PW(PW), .EW(EW), .MAX_ITER(MAX_ITER)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .p       (p),
        .q       (q),
        .e       (e),
        .busy    (busy),
        .done    (done),
        .n_o     (n_o),
        .d_o     (d_o),
        .invalid (invalid)
    );

    typedef struct {
        int unsigned     p;
        int unsigned     q;
        int unsigned     e;
        longint unsigned n;
        longint unsigned d;
        bit              inv;
        int              lat;
    } vec_t;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int unsigned x);
        if (x < 2) return 1'b0;
        for (int unsigned f = 2; f * f <= x; f++)
            if (x % f == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic longint unsigned modexp(input longint unsigned b, input longint unsigned x,
                                               input longint unsigned m);
        longint unsigned r = 1;
        longint unsigned bb = b % m;
        while (x != 0) begin
            if (x[0]) r = (r * bb) % m;
            bb = (bb * bb) % m;
            x  = x >> 1;
        end
        return r;
    endfunction

    // Key model: validity from the acceptance rules, latency from the gcd step count.
    task automatic model(input int unsigned pi, qi, ei, output longint unsigned phi,
                         output bit inv, output int lat);
        longint unsigned a, b, t;
        int k;
        phi = longint'(pi - 1) * longint'(qi - 1);
        if (pi < 2 || qi < 2 || ei < 2 || longint'(ei) >= phi) begin
            inv = 1'b1;
            lat = 3;
        end else begin
            a = phi;
            b = ei;
            k = 0;
            while (b != 0) begin
                t = a % b;
                a = b;
                b = t;
                k++;
            end
            inv = (a != 1) || (k > MAX_ITER);
            lat = k + 5;
        end
    endtask

    task automatic run_job(input int unsigned pi, qi, ei, output int cyc);
        @(posedge clk); #1;
        p = pi[PW-1:0];
        q = qi[PW-1:0];
        e = ei;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check("busy_after_accept", busy, 1);
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic verify_job(input string tag, input int unsigned pi, qi, ei, input int cyc);
        longint unsigned phi;
        bit inv;
        int lat;
        bit ok;
        model(pi, qi, ei, phi, inv, lat);
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_n"}, n_o, longint'(pi) * longint'(qi));
        check({tag, "_inv"}, invalid, inv);
        if (inv) begin
            check({tag, "_d_zero"}, d_o, 0);
        end else begin
            ok = (d_o > 0) && (longint'(d_o) < phi) && (((longint'(d_o) * ei) % phi) == 1);
            check({tag, "_d_inverse"}, ok, 1);
        end
        $display("[TB] job %s p=%0d q=%0d e=%0d -> n=%0d d=%0d invalid=%0b cycles=%0d",
                 tag, pi, qi, ei, n_o, d_o, invalid, cyc);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_clear"}, busy, 0);
    endtask

    vec_t tbl[5];
    int   cyc;
    bit   flag;

    initial begin
        tbl[0] = '{p: 61, q: 53, e: 17, n: 3233, d: 2753, inv: 1'b0, lat: 9};
        tbl[1] = '{p: 11, q: 13, e: 7,  n: 143,  d: 103,  inv: 1'b0, lat: 7};
        tbl[2] = '{p: 61, q: 53, e: 3,  n: 3233, d: 0,    inv: 1'b1, lat: 6};
        tbl[3] = '{p: 1,  q: 53, e: 17, n: 53,   d: 0,    inv: 1'b1, lat: 3};
        tbl[4] = '{p: 5,  q: 7,  e: 25, n: 35,   d: 0,    inv: 1'b1, lat: 3};

        rst = 1'b1; start = 1'b0; p = '0; q = '0; e = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_n", n_o, 0);
        check("rst_d", d_o, 0);
        check("rst_invalid", invalid, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i].p, tbl[i].q, tbl[i].e, cyc);
            check("tbl_n", n_o, tbl[i].n);
            check("tbl_d", d_o, tbl[i].d);
            check("tbl_inv", invalid, tbl[i].inv);
            check("tbl_lat", cyc, tbl[i].lat);
            verify_job("table", tbl[i].p, tbl[i].q, tbl[i].e, cyc);
        end

        repeat (10) @(posedge clk);
        #1;
        check("hold_n", n_o, 35);
        check("hold_inv", invalid, 1);

        run_job(65521, 65519, 65537, cyc);
        verify_job("maxprimes", 65521, 65519, 65537, cyc);

        // start pulsed while the first job is in EUCLID must be dropped
        run_job(61, 53, 17, cyc);
        verify_job("pre_mid", 61, 53, 17, cyc);
        @(posedge clk); #1;
        p = 16'd11; q = 16'd13; e = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        repeat (3) begin
            @(posedge clk); #1;
            cyc++;
        end
        p = 16'd5; q = 16'd7; e = 32'd5; start = 1'b1;
        check("mid_hold_n", n_o, 3233);
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("mid_done_seen", done, 1);
        verify_job("midstart", 11, 13, 7, cyc);
        flag = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy) flag = 1'b1;
        end
        check("mid_no_queue", flag, 0);

        // reset during EUCLID aborts without a done pulse
        @(posedge clk); #1;
        p = 16'd61; q = 16'd53; e = 32'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_n", n_o, 0);
        check("abort_d", d_o, 0);
        check("abort_inv", invalid, 0);
        flag = 1'b0;
        repeat (20) begin
            if (done) flag = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_done", flag, 0);
        run_job(61, 53, 17, cyc);
        check("post_abort_d", d_o, 2753);
        check("decrypt_65", modexp(2790, d_o, n_o), 65);
        verify_job("post_abort", 61, 53, 17, cyc);

        for (int i = 0; i < 200; i++) begin
            int unsigned pr, qr, er, lim;
            int unsigned mode;
            lim = ($urandom_range(0, 3) == 0) ? 100 : 65535;
            do pr = $urandom_range(2, lim); while (!is_prime(pr));
            do qr = $urandom_range(2, lim); while (!is_prime(qr));
            mode = $urandom_range(0, 2);
            if (mode == 0) er = 65537;
            else if (mode == 1) er = 3;
            else er = $urandom_range(2, (pr - 1) * (qr - 1) + 1);
            run_job(pr, qr, er, cyc);
            verify_job("random", pr, qr, er, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
